gdp_host: RTL and testbench



---
 rtl/gdp_host_if.sv | 29 ++
 rtl/gdp_host.sv | 134 +++++++++++++
 tb/tb_gdp_host.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gdp_host_if.sv
// Host-side bundle: request stream, response stream and running-sum data path controls.
interface gdp_host_if;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_n;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_sum;
    logic [7:0] rsp_n;
    logic       rsp_err;
    logic       rsp_timeout;
    logic [7:0] n_in;
    logic       start;
    logic       restart;
    logic [7:0] runSum;
    logic       done;

    modport master (
        input  req_valid, req_n, rsp_ready, runSum, done,
        output req_ready, rsp_valid, rsp_sum, rsp_n, rsp_err, rsp_timeout,
               n_in, start, restart
    );

    modport slave (
        output req_valid, req_n, rsp_ready, runSum, done,
        input  req_ready, rsp_valid, rsp_sum, rsp_n, rsp_err, rsp_timeout,
               n_in, start, restart
    );
endinterface

// File: rtl/gdp_host.sv
// Sequences one running-sum job per request: load n, pulse start, await done, check, respond, restart.
// All outputs registered; requests wait in req_ready=0 until IDLE, responses hold until rsp_ready.
module gdp_host #(
    parameter int START_CYCLES   = 2,
    parameter int RESTART_CYCLES = 2,
    parameter int TIMEOUT        = 1024
) (
    input  logic        clock,
    input  logic        reset_n,
    gdp_host_if.master  bus
);

    typedef enum logic [2:0] {IDLE, START, WAIT_DONE, RESP, RESTART} state_t;

    state_t      state, state_nxt;
    logic [3:0]  pcnt, pcnt_nxt;
    logic [15:0] tcnt, tcnt_nxt;
    logic        load, cap_done, cap_to;
    logic [7:0]  exp_w;

    logic [7:0]  n_reg, exp_reg, n_in_q, sum_q;
    logic        ready_q, start_q, restart_q, valid_q, err_q, to_q;

    // 16-bit product so n*(n+1) never overflows before the halving
    assign exp_w = 8'(({8'd0, bus.req_n} * ({8'd0, bus.req_n} + 16'd1)) >> 1);

    always_comb begin
        state_nxt = state;
        pcnt_nxt  = pcnt;
        tcnt_nxt  = tcnt;
        load      = 1'b0;
        cap_done  = 1'b0;
        cap_to    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    load      = 1'b1;
                    pcnt_nxt  = 4'd0;
                    state_nxt = START;
                end
            end
            START: begin
                if (pcnt == 4'(START_CYCLES - 1)) begin
                    pcnt_nxt  = 4'd0;
                    tcnt_nxt  = 16'd0;
                    state_nxt = WAIT_DONE;
                end else begin
                    pcnt_nxt = pcnt + 4'd1;
                end
            end
            WAIT_DONE: begin
                // done takes priority over an expiring timeout
                if (bus.done) begin
                    cap_done  = 1'b1;
                    state_nxt = RESP;
                end else if (tcnt == 16'(TIMEOUT - 1)) begin
                    cap_to    = 1'b1;
                    state_nxt = RESP;
                end else begin
                    tcnt_nxt = tcnt + 16'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    pcnt_nxt  = 4'd0;
                    state_nxt = RESTART;
                end
            end
            RESTART: begin
                if (pcnt == 4'(RESTART_CYCLES - 1)) begin
                    pcnt_nxt  = 4'd0;
                    state_nxt = IDLE;
                end else begin
                    pcnt_nxt = pcnt + 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            pcnt      <= 4'd0;
            tcnt      <= 16'd0;
            n_reg     <= 8'd0;
            exp_reg   <= 8'd0;
            n_in_q    <= 8'd0;
            sum_q     <= 8'd0;
            ready_q   <= 1'b0;
            start_q   <= 1'b0;
            restart_q <= 1'b1;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            to_q      <= 1'b0;
        end else begin
            state     <= state_nxt;
            pcnt      <= pcnt_nxt;
            tcnt      <= tcnt_nxt;
            ready_q   <= (state_nxt == IDLE);
            start_q   <= (state_nxt == START);
            restart_q <= (state_nxt == RESTART);
            valid_q   <= (state_nxt == RESP);
            if (load) begin
                n_reg   <= bus.req_n;
                exp_reg <= exp_w;
            end
            if (state_nxt == IDLE)
                n_in_q <= 8'd0;
            else if (load)
                n_in_q <= bus.req_n;
            if (cap_done) begin
                sum_q <= bus.runSum;
                err_q <= (bus.runSum != exp_reg);
                to_q  <= 1'b0;
            end else if (cap_to) begin
                sum_q <= 8'd0;
                err_q <= 1'b1;
                to_q  <= 1'b1;
            end
        end
    end

    assign bus.req_ready   = ready_q;
    assign bus.start       = start_q;
    assign bus.restart     = restart_q;
    assign bus.n_in        = n_in_q;
    assign bus.rsp_valid   = valid_q;
    assign bus.rsp_sum     = sum_q;
    assign bus.rsp_n       = n_reg;
    assign bus.rsp_err     = err_q;
    assign bus.rsp_timeout = to_q;

endmodule

// File: tb/tb_gdp_host.sv
// Directed bench for gdp_host with a behavioural running-sum data path (normal, stuck-done, corrupt-sum modes).
module tb_gdp_host;
    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp   = 0;
    int   n_err   = 0;
    int   mode    = 0;

    always #5 clock = ~clock;

    gdp_host_if bus();

    gdp_host #(.START_CYCLES(2), .RESTART_CYCLES(2), .TIMEOUT(64)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // running-sum data path: loads n on start, adds n, n-1 .. 1, then raises done until restart
    logic [7:0] m_sum  = 8'd0;
    logic [7:0] m_i    = 8'd0;
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;

    always @(posedge clock) begin
        if (bus.restart) begin
            m_sum <= 8'd0; m_i <= 8'd0; m_busy <= 1'b0; m_done <= 1'b0;
        end else if (bus.start) begin
            m_sum <= 8'd0; m_i <= bus.n_in; m_busy <= 1'b1; m_done <= 1'b0;
        end else if (m_busy) begin
            if (m_i == 8'd0) begin
                m_busy <= 1'b0;
                m_done <= (mode != 1);
            end else begin
                m_sum <= m_sum + m_i;
                m_i   <= m_i - 8'd1;
            end
        end
    end

    assign bus.done   = m_done;
    assign bus.runSum = (mode == 2) ? 8'd44 : m_sum;

    logic [7:0] q_n[$];
    logic [7:0] q_sum[$];
    logic       q_err[$];

    always @(posedge clock) begin
        if (reset_n && bus.rsp_valid && bus.rsp_ready) begin
            q_n.push_back(bus.rsp_n);
            q_sum.push_back(bus.rsp_sum);
            q_err.push_back(bus.rsp_err);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int k = 0;
        while (!bus.req_ready && k < 500) begin
            @(negedge clock);
            k++;
        end
        check(tag, 32'(k >= 500), 0);
    endtask

    task automatic send(input logic [7:0] n);
        bus.req_valid = 1'b1;
        bus.req_n     = n;
        wait_ready("send_wait");
        @(negedge clock);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_start(output int s);
        s = 0;
        while (bus.start && s < 50) begin
            s++;
            @(negedge clock);
        end
    endtask

    task automatic wait_rsp(output int c);
        c = 0;
        while (!bus.rsp_valid && c < 500) begin
            @(negedge clock);
            c++;
        end
        check("rsp_wait", 32'(c >= 500), 0);
    endtask

    task automatic take_rsp();
        bus.rsp_ready = 1'b1;
        @(negedge clock);
        bus.rsp_ready = 1'b0;
    endtask

    logic [7:0] exp_n[3];
    logic [7:0] exp_s[3];

    initial begin
        int s, c, r, k, bad;
        bus.req_valid = 1'b0;
        bus.req_n     = 8'd0;
        bus.rsp_ready = 1'b0;
        exp_n = '{8'd0, 8'd22, 8'd23};
        exp_s = '{8'd0, 8'd253, 8'd20};

        // reset
        repeat (3) @(negedge clock);
        check("rst_restart",   bus.restart,   1);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_start",     bus.start,     0);
        check("rst_n_in",      bus.n_in,      0);
        reset_n = 1'b1;
        @(negedge clock);
        check("post_rst_ready",   bus.req_ready, 1);
        check("post_rst_restart", bus.restart,   0);

        // single job n=5
        send(8'd5);
        check("n5_n_in", bus.n_in, 5);
        wait_start(s);
        check("n5_start_cycles", s, 2);
        wait_rsp(c);
        check("n5_sum",   bus.rsp_sum,     15);
        check("n5_n",     bus.rsp_n,       5);
        check("n5_err",   bus.rsp_err,     0);
        check("n5_to",    bus.rsp_timeout, 0);
        take_rsp();
        check("n5_valid_drop", bus.rsp_valid, 0);
        wait_start(s);
        r = 0;
        while (bus.restart && r < 50) begin
            r++;
            @(negedge clock);
        end
        check("n5_restart_cycles", r, 2);
        check("n5_ready_after",    bus.req_ready, 1);
        check("n5_n_in_idle",      bus.n_in, 0);

        // back-to-back 0, 22, 23 with rsp_ready tied high
        q_n.delete(); q_sum.delete(); q_err.delete();
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(exp_n[i]);
        k = 0;
        while (q_n.size() < 3 && k < 500) begin
            @(negedge clock);
            k++;
        end
        repeat (10) @(negedge clock);
        check("b2b_count", q_n.size(), 3);
        for (int i = 0; i < 3 && i < q_n.size(); i++) begin
            check("b2b_n",   q_n[i],   exp_n[i]);
            check("b2b_sum", q_sum[i], exp_s[i]);
            check("b2b_err", q_err[i], 0);
        end
        bus.rsp_ready = 1'b0;

        // done stuck low -> timeout
        mode = 1;
        send(8'd9);
        wait_start(s);
        c = 0;
        while (!bus.rsp_valid && c < 500) begin
            @(negedge clock);
            c++;
        end
        check("to_latency", c, 64);
        check("to_flag",    bus.rsp_timeout, 1);
        check("to_err",     bus.rsp_err,     1);
        check("to_sum",     bus.rsp_sum,     0);
        check("to_n",       bus.rsp_n,       9);
        take_rsp();
        mode = 0;

        // corrupted sum
        wait_ready("idle_wait");
        mode = 2;
        send(8'd8);
        wait_rsp(c);
        check("bad_sum", bus.rsp_sum,     44);
        check("bad_err", bus.rsp_err,     1);
        check("bad_to",  bus.rsp_timeout, 0);
        take_rsp();
        wait_ready("idle_wait");
        mode = 0;

        // back-pressure with a second request pending
        send(8'd4);
        wait_rsp(c);
        bus.req_valid = 1'b1;
        bus.req_n     = 8'd7;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.rsp_valid !== 1'b1 || bus.rsp_sum !== 8'd10 || bus.req_ready !== 1'b0) bad++;
            @(negedge clock);
        end
        check("bp_stall_cycles_bad", bad, 0);
        check("bp_sum", bus.rsp_sum, 10);
        take_rsp();
        wait_ready("bp_second_accept");
        @(negedge clock);
        bus.req_valid = 1'b0;
        wait_rsp(c);
        check("bp2_n",   bus.rsp_n,   7);
        check("bp2_sum", bus.rsp_sum, 28);
        check("bp2_err", bus.rsp_err, 0);
        take_rsp();
        wait_ready("idle_wait");

        // reset asserted in WAIT_DONE
        mode = 1;
        bus.rsp_ready = 1'b1;
        send(8'd3);
        wait_start(s);
        repeat (5) @(negedge clock);
        q_n.delete(); q_sum.delete(); q_err.delete();
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid",   bus.rsp_valid, 0);
        check("mid_rst_restart", bus.restart,   1);
        check("mid_rst_start",   bus.start,     0);
        repeat (2) @(negedge clock);
        mode = 0;
        reset_n = 1'b1;
        @(negedge clock);
        check("mid_rst_idle", bus.req_ready, 1);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus.rsp_valid !== 1'b0) bad++;
            @(negedge clock);
        end
        check("mid_rst_no_rsp",   bad, 0);
        check("mid_rst_no_hs",    q_n.size(), 0);
        check("mid_rst_ready",    bus.req_ready, 1);
        bus.rsp_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
